boxin_dac_tx: RTL

- Serial DAC transmitter for the DDS output path.
- Takes the 10-bit selected waveform sample (boxin) and shifts it MSB-first to an external TLC5615-class 10-bit serial DAC.
- Frame is 12 bits: 10 data bits followed by 2 zero pad bits. Uses CS_n/SCLK/DIN signalling.
- Sits directly downstream of the waveform-select mux. A start strobe from the phase-accumulator sample tick triggers one DAC update per sample.

---
 rtl/boxin_dac_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/boxin_dac_tx.sv
// boxin_dac_tx: serial transmitter feeding a TLC5615-class 10-bit DAC.
// Shifts one boxin sample MSB-first per qidong strobe over CS_n/SCLK/DIN.
//
// Ports:
//   clk, rst_n     system clock, async active-low reset
//   boxin          sample, captured on an accepted start
//   qidong         start strobe, honoured only while idle
//   mang           busy flag
//   wancheng       one-cycle frame-done pulse
//   dac_cs_n       DAC chip select (active low)
//   dac_sclk       DAC serial clock (idle low)
//   dac_din        DAC serial data
module boxin_dac_tx #(
    parameter int DATA_W     = 10,
    parameter int PAD_BITS   = 2,
    parameter int CLK_DIV    = 4,
    parameter int GAP_HALVES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] boxin,
    input  logic              qidong,
    output logic              mang,
    output logic              wancheng,
    output logic              dac_cs_n,
    output logic              dac_sclk,
    output logic              dac_din
);

    localparam int NB       = DATA_W + PAD_BITS;
    localparam int GAP_CLKS = GAP_HALVES * CLK_DIV;
    localparam int DMAX     = (GAP_CLKS > CLK_DIV) ? GAP_CLKS : CLK_DIV;
    localparam int DW       = $clog2(DMAX) + 1;
    localparam int BW       = $clog2(NB + 1);

    // The IDLE cycle carrying wancheng is the last CS_n-high gap clock,
    // so the GAP state itself only lasts GAP_CLKS-1 clocks. With a
    // one-clock gap the GAP state is skipped entirely.
    localparam bit             HAS_GAP  = (GAP_CLKS > 1);
    localparam logic [DW-1:0]  HALF_END = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]  GAP_END  = DW'(HAS_GAP ? GAP_CLKS - 2 : 0);
    localparam logic [BW-1:0]  NB_C     = BW'(NB);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        GAP
    } state_e;

    state_e          st_q, st_d;
    logic [DW-1:0]   div_q, div_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [NB-1:0]   sh_q, sh_d;
    logic            mang_q, mang_d;
    logic            wan_q, wan_d;
    logic            cs_q, cs_d;
    logic            sclk_q, sclk_d;
    logic            din_q, din_d;
    logic            active;

    always_comb begin
        st_d  = st_q;
        div_d = div_q + 1'b1;
        bit_d = bit_q;
        sh_d  = sh_q;
        wan_d = 1'b0;
        unique case (st_q)
            IDLE: begin
                div_d = '0;
                bit_d = '0;
                if (qidong) begin
                    sh_d = NB'(boxin) << PAD_BITS;
                    st_d = SETUP;
                end
            end
            SETUP: begin
                if (div_q == HALF_END) begin
                    div_d = '0;
                    st_d  = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                // Shift happens on the edge entering SHIFT_LO so DIN
                // changes half a period away from the SCLK rise.
                if (div_q == HALF_END) begin
                    div_d = '0;
                    bit_d = bit_q + 1'b1;
                    sh_d  = sh_q << 1;
                    st_d  = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_q == HALF_END) begin
                    div_d = '0;
                    if (bit_q < NB_C) begin
                        st_d = SHIFT_HI;
                    end else if (HAS_GAP) begin
                        st_d = GAP;
                    end else begin
                        st_d  = IDLE;
                        wan_d = 1'b1;
                    end
                end
            end
            GAP: begin
                if (div_q == GAP_END) begin
                    div_d = '0;
                    st_d  = IDLE;
                    wan_d = 1'b1;
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from next state so they register in step
    // with the FSM. After the last shift sh_d is all zero, so DIN
    // drops to 0 without extra logic.
    always_comb begin
        active = (st_d == SETUP) || (st_d == SHIFT_HI) || (st_d == SHIFT_LO);
        cs_d   = !active;
        sclk_d = (st_d == SHIFT_HI);
        din_d  = active && sh_d[NB-1];
        mang_d = (st_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            div_q  <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            mang_q <= 1'b0;
            wan_q  <= 1'b0;
            cs_q   <= 1'b1;
            sclk_q <= 1'b0;
            din_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            div_q  <= div_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            mang_q <= mang_d;
            wan_q  <= wan_d;
            cs_q   <= cs_d;
            sclk_q <= sclk_d;
            din_q  <= din_d;
        end
    end

    assign mang     = mang_q;
    assign wancheng = wan_q;
    assign dac_cs_n = cs_q;
    assign dac_sclk = sclk_q;
    assign dac_din  = din_q;

endmodule
